symbol_counter: RTL and testbench
=================================

SYMBOL_COUNTER -- requirements
Module: symbol_counter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port gray_valid, input, 1 bit: gray_data holds a symbol this cycle.
REQ-004 The block SHALL have the port gray_data, input, 8 bits: symbol value; legal values are 1..6.
REQ-005 The block SHALL have the ports CNT1..CNT6, output, 8 bits each: occurrence count of symbols 1..6 in the current or last frame.
REQ-006 The block SHALL have the port CNT_valid, output, 1 bit: one-cycle pulse; CNT1..CNT6 are final for the frame.
REQ-007 The block SHALL have the port cnt_err, output, 1 bit: sticky per frame; the frame contained at least one illegal symbol.
REQ-008 The block SHALL have the port cnt_total, output, 8 bits: number of legal symbols counted in the frame.

Function
REQ-009 The block SHALL implement a frame FSM with states IDLE, COUNT, DONE and HOLD, encoded in 2 bits.
REQ-010 A frame SHALL be a maximal run of consecutive cycles with gray_valid=1.
REQ-011 In IDLE or HOLD, gray_valid=1 SHALL clear CNT1..6, cnt_total and cnt_err, count the current symbol in the same cycle, and move to COUNT.
REQ-012 In COUNT, gray_valid=1 SHALL add 1 to CNTk, where k = gray_data, and to cnt_total; the FSM SHALL stay in COUNT.
REQ-013 Counters SHALL saturate at 255 and never wrap.
REQ-014 When gray_data is 0 or greater than 6, the block SHALL change no count and SHALL set cnt_err to 1.
REQ-015 In COUNT, gray_valid=0 SHALL move the FSM to DONE.
REQ-016 CNT_valid SHALL go to 1 on that same clock edge, registered, and SHALL stay 1 for exactly one cycle.
REQ-017 CNT_valid SHALL be 1 only in DONE.
REQ-018 DONE SHALL go to HOLD if gray_valid=0.
REQ-019 If gray_valid=1 in DONE, the block SHALL start a new frame as in REQ-011 and move to COUNT; CNT_valid SHALL still fall after its one cycle.
REQ-020 In HOLD, all count outputs SHALL hold their values until the next frame starts.
REQ-021 gray_valid=0 in IDLE SHALL keep the FSM in IDLE.
REQ-022 CNT1..6, cnt_total and cnt_err SHALL be driven directly from registers, with no combinational path from any input.
REQ-023 An all-illegal frame SHALL still pulse CNT_valid, with all counts 0 and cnt_err=1.
REQ-024 After any increment, the sum of CNT1..CNT6 SHALL equal cnt_total, unless some counter has saturated.

Reset
REQ-025 reset=1 at a clock edge SHALL force the FSM to IDLE and every output to 0.
REQ-026 Reset SHALL take priority over gray_valid.
REQ-027 Reset in the middle of a frame SHALL discard that frame; no CNT_valid SHALL follow.
REQ-028 The first frame after reset is released SHALL be counted from zero.

Structure
REQ-029 A shared package SHALL hold the FSM state encodings, the symbol range constants (SYM_MIN=1, SYM_MAX=6, NUM_SYM=6) and the count width (8).
REQ-030 The downstream sorting/encoding stage SHALL use the same package.
REQ-031 One sub-module, sat_counter, SHALL be used: an 8-bit counter with clear and saturating increment, instantiated 7 times (six symbol counts plus the total).
REQ-032 The FSM and the symbol decode SHALL stay in symbol_counter.

Verification
REQ-033 The bench SHALL cover this scenario: a frame of 1,2,2,3,3,3,4,5,6,6 then gray_valid=0. The required response is CNT = 1,2,3,1,1,2, cnt_total=10, cnt_err=0, and CNT_valid high for exactly 1 cycle, starting at the edge that samples gray_valid=0.
REQ-034 The bench SHALL cover this scenario: 300 cycles of symbol 4. The required response is CNT4=255, cnt_total=255, and all other counts 0.
REQ-035 The bench SHALL cover this scenario: a frame of 0,7,3,255. The required response is CNT3=1, cnt_total=1, cnt_err=1, and CNT_valid pulses.
REQ-036 The bench SHALL cover this scenario: a frame of 1,1, one idle cycle, then a frame of 2, with gray_valid=1 in the DONE cycle. The required response is a first pulse showing CNT1=2, then a second pulse showing CNT1=0 and CNT2=1.
REQ-037 The bench SHALL cover this scenario: reset asserted after 3 symbols of a frame. The required response is all outputs 0 on the next edge, no CNT_valid, and the next frame counted from zero.
REQ-038 The bench SHALL cover this scenario: 20 idle cycles after a frame. The required response is outputs unchanged throughout HOLD and CNT_valid staying 0.

Source files
------------

// File: rtl/symbol_counter_pkg.sv
// Shared constants and types for the symbol counting and downstream sort/encode stages.
// Holds FSM state encodings, the legal symbol range and the count width.
package symbol_counter_pkg;

    localparam int SYM_W   = 8;
    localparam int CNT_W   = 8;
    localparam int SYM_MIN = 1;
    localparam int SYM_MAX = 6;
    localparam int NUM_SYM = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    function automatic logic sym_legal(input logic [SYM_W-1:0] sym);
        return (sym >= SYM_W'(SYM_MIN)) && (sym <= SYM_W'(SYM_MAX));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Counter with synchronous clear and saturating increment; clear+inc loads 1.
// Single-cycle update, saturates at all-ones and holds there.
module sat_counter
    import symbol_counter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/symbol_counter.sv
// Per-frame histogram of symbols 1..6 with legal-symbol total and sticky illegal flag.
// Counts update on the sampling edge; CNT_valid pulses one cycle after the frame's last symbol.
module symbol_counter
    import symbol_counter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             gray_valid,
    input  logic [SYM_W-1:0] gray_data,
    output logic [CNT_W-1:0] CNT1,
    output logic [CNT_W-1:0] CNT2,
    output logic [CNT_W-1:0] CNT3,
    output logic [CNT_W-1:0] CNT4,
    output logic [CNT_W-1:0] CNT5,
    output logic [CNT_W-1:0] CNT6,
    output logic             CNT_valid,
    output logic             cnt_err,
    output logic [CNT_W-1:0] cnt_total
);

    state_t state, state_nxt;
    logic   frame_start;
    logic   legal;
    logic   [CNT_W-1:0] sym_cnt [NUM_SYM];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (gray_valid) state_nxt = S_COUNT;
            S_COUNT: if (!gray_valid) state_nxt = S_DONE;
            S_DONE:  state_nxt = gray_valid ? S_COUNT : S_HOLD;
            S_HOLD:  if (gray_valid) state_nxt = S_COUNT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Any valid symbol outside COUNT opens a new frame, including back-to-back from DONE.
    assign frame_start = gray_valid && (state != S_COUNT);
    assign legal       = sym_legal(gray_data);

    for (genvar k = 0; k < NUM_SYM; k++) begin : g_sym
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (frame_start),
            .inc   (gray_valid && legal && (gray_data == SYM_W'(k + SYM_MIN))),
            .count (sym_cnt[k])
        );
    end

    sat_counter #(.W(CNT_W)) u_total (
        .clk   (clk),
        .reset (reset),
        .clr   (frame_start),
        .inc   (gray_valid && legal),
        .count (cnt_total)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_err <= 1'b0;
        end else if (frame_start) begin
            cnt_err <= !legal;
        end else if (gray_valid) begin
            cnt_err <= cnt_err | !legal;
        end
    end

    assign CNT_valid = (state == S_DONE);
    assign CNT1 = sym_cnt[0];
    assign CNT2 = sym_cnt[1];
    assign CNT3 = sym_cnt[2];
    assign CNT4 = sym_cnt[3];
    assign CNT5 = sym_cnt[4];
    assign CNT6 = sym_cnt[5];

endmodule

// File: tb/tb_symbol_counter.sv
// Bench for symbol_counter: directed frame scenarios plus randomized traffic
// against a per-frame histogram model.
module tb_symbol_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       gray_valid = 1'b0;
    logic [7:0] gray_data = 8'd0;
    logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6, cnt_total;
    logic       CNT_valid, cnt_err;
    logic [7:0] dut_cnt [1:6];

    int checks = 0;
    int errors = 0;

    int m_cnt [1:6];
    int m_total;
    bit m_err, m_valid, m_in_frame;

    always #5 clk = ~clk;

    symbol_counter dut (
        .clk        (clk),
        .reset      (reset),
        .gray_valid (gray_valid),
        .gray_data  (gray_data),
        .CNT1       (CNT1),
        .CNT2       (CNT2),
        .CNT3       (CNT3),
        .CNT4       (CNT4),
        .CNT5       (CNT5),
        .CNT6       (CNT6),
        .CNT_valid  (CNT_valid),
        .cnt_err    (cnt_err),
        .cnt_total  (cnt_total)
    );

    assign dut_cnt[1] = CNT1;
    assign dut_cnt[2] = CNT2;
    assign dut_cnt[3] = CNT3;
    assign dut_cnt[4] = CNT4;
    assign dut_cnt[5] = CNT5;
    assign dut_cnt[6] = CNT6;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Histogram model: a frame is a run of valid cycles; its results are
    // published the cycle after the run ends.
    task automatic model_update(input bit rst, input bit gv, input logic [7:0] d);
        if (rst) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_total = 0; m_err = 0; m_valid = 0; m_in_frame = 0;
        end else if (gv) begin
            if (!m_in_frame) begin
                foreach (m_cnt[k]) m_cnt[k] = 0;
                m_total = 0; m_err = 0;
            end
            if (d >= 1 && d <= 6) begin
                if (m_cnt[int'(d)] < 255) m_cnt[int'(d)]++;
                if (m_total < 255) m_total++;
            end else begin
                m_err = 1;
            end
            m_in_frame = 1;
            m_valid = 0;
        end else begin
            m_valid = m_in_frame;
            m_in_frame = 0;
        end
    endtask

    task automatic compare_all();
        for (int k = 1; k <= 6; k++) chk($sformatf("CNT%0d", k), dut_cnt[k], m_cnt[k]);
        chk("cnt_total", cnt_total, m_total);
        chk("cnt_err", cnt_err, m_err);
        chk("CNT_valid", CNT_valid, m_valid);
    endtask

    task automatic step(input bit rst, input bit gv, input logic [7:0] d);
        @(negedge clk);
        reset = rst; gray_valid = gv; gray_data = d;
        @(posedge clk);
        model_update(rst, gv, d);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'd0);
    endtask

    initial begin
        logic [7:0] frame1 [10];
        frame1 = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd4, 8'd5, 8'd6, 8'd6};
        foreach (m_cnt[k]) m_cnt[k] = 0;
        m_total = 0; m_err = 0; m_valid = 0; m_in_frame = 0;

        step(1, 0, 8'd0);
        step(1, 0, 8'd0);
        chk("rst_total", cnt_total, 0);
        chk("rst_valid", CNT_valid, 0);
        idle(2);

        // Reference frame with known histogram
        foreach (frame1[i]) step(0, 1, frame1[i]);
        step(0, 0, 8'd0);
        chk("f1_valid", CNT_valid, 1);
        chk("f1_cnt", {CNT1, CNT2, CNT3, CNT4, CNT5, CNT6}, {8'd1, 8'd2, 8'd3, 8'd1, 8'd1, 8'd2});
        chk("f1_total", cnt_total, 10);
        chk("f1_err", cnt_err, 0);
        step(0, 0, 8'd0);
        chk("f1_pulse_fall", CNT_valid, 0);

        // Saturation
        for (int i = 0; i < 300; i++) step(0, 1, 8'd4);
        step(0, 0, 8'd0);
        chk("sat_cnt4", CNT4, 255);
        chk("sat_total", cnt_total, 255);
        chk("sat_others", {CNT1, CNT2, CNT3, CNT5, CNT6}, 0);
        chk("sat_valid", CNT_valid, 1);
        idle(2);

        // Illegal symbols mixed with a legal one
        step(0, 1, 8'd0); step(0, 1, 8'd7); step(0, 1, 8'd3); step(0, 1, 8'd255);
        step(0, 0, 8'd0);
        chk("ill_cnt3", CNT3, 1);
        chk("ill_total", cnt_total, 1);
        chk("ill_err", cnt_err, 1);
        chk("ill_valid", CNT_valid, 1);
        idle(1);

        // All-illegal frame
        step(0, 1, 8'd0); step(0, 1, 8'd9);
        step(0, 0, 8'd0);
        chk("allill_valid", CNT_valid, 1);
        chk("allill_total", cnt_total, 0);
        chk("allill_err", cnt_err, 1);
        idle(1);

        // New frame starting in the DONE cycle
        step(0, 1, 8'd1); step(0, 1, 8'd1);
        step(0, 0, 8'd0);
        chk("b2b_p1_valid", CNT_valid, 1);
        chk("b2b_p1_cnt1", CNT1, 2);
        step(0, 1, 8'd2);
        chk("b2b_fall", CNT_valid, 0);
        step(0, 0, 8'd0);
        chk("b2b_p2_valid", CNT_valid, 1);
        chk("b2b_p2_cnt", {CNT1, CNT2}, {8'd0, 8'd1});
        idle(2);

        // Reset mid-frame, with gray_valid still high
        step(0, 1, 8'd5); step(0, 1, 8'd5); step(0, 1, 8'd2);
        step(1, 1, 8'd5);
        chk("mid_rst_zero", {CNT1, CNT2, CNT5, cnt_total, 7'd0, cnt_err}, 0);
        chk("mid_rst_valid", CNT_valid, 0);
        step(0, 0, 8'd0);
        chk("mid_rst_nopulse", CNT_valid, 0);
        step(0, 1, 8'd6); step(0, 1, 8'd6);
        step(0, 0, 8'd0);
        chk("post_rst_cnt6", CNT6, 2);
        chk("post_rst_total", cnt_total, 2);

        // Long HOLD
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 8'd0);
            chk("hold_cnt6", CNT6, 2);
            chk("hold_valid", CNT_valid, 0);
        end

        // Randomized traffic: short and long frame phases
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 500; i++) begin
                bit rst, gv;
                logic [7:0] d;
                rst = ($urandom_range(0, 199) == 0);
                gv  = (ph % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) != 0);
                if ($urandom_range(0, 9) == 0) begin
                    d = 8'($urandom_range(0, 255));
                    if (d >= 1 && d <= 6) d = 8'd0;
                end else begin
                    d = 8'($urandom_range(1, 6));
                end
                step(rst, gv, d);
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
